// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - AXI4 read-only instruction-memory port (AR + R channels)
interface if_fetch_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: one single-beat AXI read per PC, loads IF/ID
module if_fetch (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic              redirect,
  input  logic              id_hold,
  input  logic              dm_stall,
  output logic              pc_stall,
  if_fetch_if.master        axi,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic              fetch_err,
  output logic [31:0]       fetch_cnt
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, AR, R} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        done;
  logic        unused_ok;

  // rlast is ignored: every burst is a single beat; PC low bits are forced to word alignment.
  assign unused_ok = ^{axi.rlast, pc_in[1:0]};

  assign done     = (state_q == R) && axi.rvalid && !dm_stall;
  assign pc_stall = !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = AR;
      AR:      if (axi.arvalid && axi.arready) state_d = R;
      R:       if (done) state_d = AR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi.arvalid = 1'b0;
    axi.araddr  = 32'h0;
    axi.rready  = 1'b0;
    axi.arlen   = 8'd0;
    axi.arsize  = 3'b010;
    axi.arburst = 2'b01;
    case (state_q)
      AR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = {pc_in[31:2], 2'b00};
      end
      R:       axi.rready = !dm_stall;
      default: ;
    endcase
  end

  // IF/ID only moves on the completing beat; priority redirect > hold > error > load.
  always_comb begin
    addr_d      = addr_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;
    if (axi.arvalid && axi.arready) begin
      addr_d = axi.araddr;
    end
    if (done) begin
      if (redirect) begin
        if_instr_d = NOP;
        if_valid_d = 1'b0;
        if_pc_d    = addr_q;
      end else if (id_hold) begin
        if_valid_d = if_valid_q;
      end else if (axi.rresp != 2'b00) begin
        if_instr_d  = NOP;
        if_valid_d  = 1'b0;
        fetch_err_d = 1'b1;
      end else begin
        if_instr_d  = axi.rdata;
        if_pc_d     = addr_q;
        if_valid_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= 32'h0;
      if_pc_q     <= 32'h0;
      if_instr_q  <= NOP;
      if_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;
  assign fetch_err = fetch_err_q;
  assign fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch with a scripted AXI slave
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = 32'h0;
  logic        redirect = 1'b0;
  logic        id_hold = 1'b0;
  logic        dm_stall = 1'b0;
  logic        pc_stall;
  logic [31:0] if_pc, if_instr, fetch_cnt;
  logic        if_valid, fetch_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t mdl;

  if_fetch_if bus ();

  if_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .redirect  (redirect),
    .id_hold   (id_hold),
    .dm_stall  (dm_stall),
    .pc_stall  (pc_stall),
    .axi       (bus),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_valid  (if_valid),
    .fetch_err (fetch_err),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl.pc = 32'h0; mdl.instr = NOP; mdl.valid = 1'b0; mdl.err = 1'b0; mdl.cnt = 32'h0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_arvalid"}, bus.arvalid, 1'b0);
    check({pfx, "_rready"}, bus.rready, 1'b0);
    check({pfx, "_araddr"}, bus.araddr, 32'h0);
    check({pfx, "_if_pc"}, if_pc, 32'h0);
    check({pfx, "_if_instr"}, if_instr, NOP);
    check({pfx, "_if_valid"}, if_valid, 1'b0);
    check({pfx, "_fetch_err"}, fetch_err, 1'b0);
    check({pfx, "_fetch_cnt"}, fetch_cnt, 32'h0);
    check({pfx, "_pc_stall"}, pc_stall, 1'b1);
  endtask

  // One fetch transaction; entered with the DUT in IDLE/AR, leaves it in AR.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                       input int ar_dly, input int r_dly, input int dm_cyc,
                       input logic redir, input logic hold);
    int          n;
    logic [31:0] a;
    exp_t        e;
    a = {addr[31:2], 2'b00};
    pc_in = addr;
    #1;
    n = 0;
    while (!bus.arvalid && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    check("arvalid_up", bus.arvalid, 1'b1);
    for (int i = 0; i < ar_dly; i++) begin
      check("araddr_hold", bus.araddr, a);
      check("pc_stall_ar", pc_stall, 1'b1);
      @(posedge clk); #2;
    end
    bus.arready = 1'b1;
    #1;
    check("araddr", bus.araddr, a);
    @(posedge clk); #1;
    bus.arready = 1'b0;
    #1;
    check("arvalid_down", bus.arvalid, 1'b0);
    for (int i = 0; i < r_dly; i++) begin
      check("rready_wait", bus.rready, 1'b1);
      check("pc_stall_r", pc_stall, 1'b1);
      @(posedge clk); #2;
    end
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    dm_stall   = (dm_cyc > 0);
    #1;
    for (int i = 0; i < dm_cyc; i++) begin
      check("rready_dm", bus.rready, 1'b0);
      check("pc_stall_dm", pc_stall, 1'b1);
      @(posedge clk); #2;
    end
    dm_stall = 1'b0;
    redirect = redir;
    id_hold  = hold;
    #1;
    check("pc_stall_done", pc_stall, 1'b0);
    check("rready_done", bus.rready, 1'b1);
    if (redir) begin
      mdl.instr = NOP; mdl.valid = 1'b0; mdl.pc = a;
    end else if (hold) begin
      mdl.valid = mdl.valid;
    end else if (resp != 2'b00) begin
      mdl.instr = NOP; mdl.valid = 1'b0; mdl.err = 1'b1;
    end else begin
      mdl.instr = data; mdl.pc = a; mdl.valid = 1'b1; mdl.cnt = mdl.cnt + 32'd1;
    end
    sb_q.push_back(mdl);
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    redirect   = 1'b0;
    id_hold    = 1'b0;
    #1;
    e = sb_q.pop_front();
    check("if_pc", if_pc, e.pc);
    check("if_instr", if_instr, e.instr);
    check("if_valid", if_valid, e.valid);
    check("fetch_err", fetch_err, e.err);
    check("fetch_cnt", fetch_cnt, e.cnt);
    check("pc_stall_after", pc_stall, 1'b1);
  endtask

  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    check("arlen", bus.arlen, 8'd0);
    check("arsize", bus.arsize, 3'b010);
    check("arburst", bus.arburst, 2'b01);
    rst = 1'b0;
    #1;
    check("arvalid_idle", bus.arvalid, 1'b0);
    @(posedge clk); #2;
    check("arvalid_first", bus.arvalid, 1'b1);

    fetch(32'h0, 32'h0050_0093, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h4, 32'h1111_2222, 2'b00, 3, 4, 0, 1'b0, 1'b0);
    fetch(32'h8, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    fetch(32'h40, 32'h0000_A0B3, 2'b00, 1, 0, 0, 1'b0, 1'b0);
    fetch(32'h10, 32'h3333_4444, 2'b00, 0, 1, 0, 1'b0, 1'b1);
    fetch(32'h10, 32'h3333_4444, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h14, 32'h5555_6666, 2'b00, 0, 0, 5, 1'b0, 1'b0);
    fetch(32'h20, 32'h7777_8888, 2'b10, 0, 0, 0, 1'b0, 1'b0);
    fetch(32'h24, 32'h9999_AAAA, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      fetch(32'h100 + 32'(i) * 4, $urandom, 2'b00, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    pc_in = 32'h200;
    #1;
    check("arvalid_pre_rst", bus.arvalid, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    @(posedge clk); #2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
